// File: rtl/instr_pkg.sv
// Shared instruction-format definitions used by the loader, the processor and the scheduler.
package instr_pkg;

  localparam int INSTR_W           = 12;
  localparam int NIBBLE_W          = 4;
  localparam int NIBBLES_PER_INSTR = 3;

  typedef logic [INSTR_W-1:0]  instr_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Assembler phase: which nibble of the word the next transfer carries.
  typedef enum logic [1:0] {
    PH_HI  = 2'd0,
    PH_MID = 2'd1,
    PH_LO  = 2'd2
  } phase_e;

  function automatic instr_t make_word(input logic [INSTR_W-NIBBLE_W-1:0] hold,
                                       input nibble_t nib);
    return {hold, nib};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; the head word reads as zero when empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign push_ok_s = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok_s  = pop_i && (count_q != CNT_W'(0));

  // Pointer and occupancy next state; flush overrides any handshake in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(0);
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    if (count_q != CNT_W'(0)) begin
      data_o = mem_q[rd_ptr_q];
    end else begin
      data_o = WIDTH'(0);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/instr_loader.sv
// Nibble-serial instruction assembler (MSB nibble first) feeding a word FIFO towards the scheduler.
module instr_loader
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [CNT_W-1:0]    count,
  output logic [1:0]          phase
);

  localparam int HOLD_W = INSTR_W - NIBBLE_W;

  phase_e             phase_q, phase_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               nib_xfer_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   count_s;

  // Only the last nibble needs FIFO space; the first two are held in the assembler.
  assign in_ready   = !flush && ((phase_q != PH_LO) || (count_s != CNT_W'(DEPTH)));
  assign nib_xfer_s = in_valid && in_ready;
  assign push_s     = nib_xfer_s && (phase_q == PH_LO);
  assign instr_valid = (count_s != CNT_W'(0));
  assign pop_s      = instr_valid && instr_ready;

  // Assembler next state: phase advances and the holding register loads only on a nibble transfer.
  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    if (flush) begin
      phase_d = PH_HI;
      hold_d  = HOLD_W'(0);
    end else if (nib_xfer_s) begin
      case (phase_q)
        PH_HI: begin
          hold_d[HOLD_W-1 -: NIBBLE_W] = in_data;
          phase_d = PH_MID;
        end
        PH_MID: begin
          hold_d[NIBBLE_W-1:0] = in_data;
          phase_d = PH_LO;
        end
        PH_LO: begin
          phase_d = PH_HI;
        end
        default: begin
          phase_d = PH_HI;
        end
      endcase
    end else begin
      phase_d = phase_q;
      hold_d  = hold_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_HI;
      hold_q  <= HOLD_W'(0);
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_s),
    .data_i  (make_word(hold_q, in_data)),
    .pop_i   (pop_s),
    .flush_i (flush),
    .data_o  (instruction),
    .count_o (count_s)
  );

  assign count = count_s;
  assign phase = phase_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, directed corner sequences and random traffic
// compared against a queue-based reference model.
module tb_instr_loader;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [11:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  count;
  logic [1:0]  phase;

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count),
    .phase       (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [11:0] mq[$];   // words the loader should currently hold, head first
  logic [3:0]  mn[$];   // nibbles of the partially received word
  logic [11:0] got[$];  // words actually handed to the consumer

  typedef struct {
    logic        fl;
    logic        iv;
    logic [3:0]  d;
    logic        ir;
    logic        ev;
    logic [11:0] ei;
    int          ec;
    int          ep;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mn.delete();
  endtask

  // One clock cycle: drive, check in_ready mid-cycle, advance model at the edge, check state after.
  task automatic step(input logic fl, input logic iv, input logic [3:0] d, input logic ir,
                      output logic acc);
    logic exp_rdy;
    logic out_acc;
    flush = fl; in_valid = iv; in_data = d; instr_ready = ir;
    #3;
    exp_rdy = !fl && (mn.size() != 2 || mq.size() != DEPTH);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    if (instr_valid && ir) got.push_back(instruction);
    acc = iv && exp_rdy;
    out_acc = (mq.size() != 0) && ir;
    @(posedge clock);
    if (fl) begin
      model_reset();
    end else begin
      if (out_acc) void'(mq.pop_front());
      if (acc) begin
        mn.push_back(d);
        if (mn.size() == 3) begin
          mq.push_back({mn[0], mn[1], mn[2]});
          mn.delete();
        end
      end
    end
    #1;
    chk("instr_valid", int'(instr_valid), int'(mq.size() != 0));
    chk("instruction", int'(instruction), (mq.size() != 0) ? int'(mq[0]) : 0);
    chk("count", int'(count), mq.size());
    chk("phase", int'(phase), mn.size());
  endtask

  task automatic send_word(input logic [11:0] w, input logic ir);
    logic a;
    logic [11:0] wv;
    wv = w;
    step(1'b0, 1'b1, wv[11:8], ir, a);
    step(1'b0, 1'b1, wv[7:4],  ir, a);
    step(1'b0, 1'b1, wv[3:0],  ir, a);
  endtask

  initial begin
    logic a;
    logic ivc;
    logic [11:0] w;
    int n;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; instr_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_instr_valid", int'(instr_valid), 0);
    chk("rst_instruction", int'(instruction), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_phase", int'(phase), 0);
    #9 reset = 1'b0;
    @(posedge clock); #1;

    // A53 assembly and pop, then partial F0? discarded by flush, then 123.
    vecs[0]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 12'h000, 0, 1};
    vecs[1]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 12'h000, 0, 2};
    vecs[2]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 12'hA53, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 12'h000, 0, 1};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 12'h000, 0, 2};
    vecs[6]  = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 12'h000, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 12'h000, 0, 1};
    vecs[8]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 12'h000, 0, 2};
    vecs[9]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 12'h123, 1, 0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000, 0, 0};
    got.delete();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ir, a);
      chk($sformatf("vec%0d_valid", i), int'(instr_valid), int'(vecs[i].ev));
      chk($sformatf("vec%0d_instr", i), int'(instruction), int'(vecs[i].ei));
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].ec);
      chk($sformatf("vec%0d_phase", i), int'(phase), vecs[i].ep);
    end
    chk("flush_words_out", got.size(), 2);
    if (got.size() == 2) chk("flush_word1", int'(got[1]), 12'h123);

    // Fill the FIFO, stall on the fifth word's last nibble, then drain.
    for (int i = 0; i < 4; i++) send_word(12'h101 + 12'(i), 1'b0);
    step(1'b0, 1'b1, 4'h1, 1'b0, a);
    step(1'b0, 1'b1, 4'h0, 1'b0, a);
    chk("full_count", int'(count), 4);
    chk("full_phase", int'(phase), 2);
    step(1'b0, 1'b1, 4'h5, 1'b0, a);
    chk("stall_no_accept", int'(a), 0);
    got.delete();
    ivc = 1'b1;
    n = 0;
    while (got.size() < 5 && n < 20) begin
      step(1'b0, ivc, 4'h5, 1'b1, a);
      if (a) ivc = 1'b0;
      n++;
    end
    chk("drain_words", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("drain_word%0d", i), int'(got[i]), 12'h101 + i);

    // Continuous streaming with the consumer always ready.
    got.delete();
    for (int i = 0; i < 5; i++) begin
      w = 12'(32'h3C1 * (i + 1));
      send_word(w, 1'b1);
      chk("stream_count_le1", int'(count <= 3'd1), 1);
    end
    step(1'b0, 1'b0, 4'h0, 1'b1, a);
    chk("stream_words", got.size(), 5);

    // Flush together with a pop and an offered nibble while two words are buffered.
    send_word(12'hABC, 1'b0);
    send_word(12'hDEF, 1'b0);
    step(1'b1, 1'b1, 4'h9, 1'b1, a);
    chk("flushpop_count", int'(count), 0);
    chk("flushpop_valid", int'(instr_valid), 0);
    chk("flushpop_phase", int'(phase), 0);

    // Asynchronous reset mid-word with three words buffered.
    for (int i = 0; i < 3; i++) send_word(12'h111 * (i + 1), 1'b0);
    step(1'b0, 1'b1, 4'hE, 1'b0, a);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_valid", int'(instr_valid), 0);
    chk("arst_instr", int'(instruction), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_phase", int'(phase), 0);
    model_reset();
    #2 reset = 1'b0;
    @(posedge clock); #1;
    send_word(12'h789, 1'b0);
    chk("post_rst_word", int'(instruction), 12'h789);
    chk("post_rst_count", int'(count), 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 24) == 0), 1'($urandom), 4'($urandom), 1'($urandom), a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Instruction front end for the processor: accepts the 12-bit instruction stream nibble-serially over a 4-bit valid/ready input port, the input-pin budget of the tapeout, and assembles each word MSB nibble first. Complete words are buffered in a small FIFO and presented to the scheduler over a valid/ready port. A synchronous flush, driven from the scheduler's clear/instr_fault, discards all buffered and partial instructions.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- INSTR_W, 12: instruction width; fixed by the package, not overridden.
- NIBBLE_W, 4: input port width; INSTR_W / NIBBLE_W = 3 nibbles per instruction.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_data  in  4  instruction nibble.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a nibble this cycle.
- flush  in  1  synchronous clear of FIFO and assembler.
- instruction  out  12  FIFO head word.
- instr_valid  out  1  instruction holds a valid word.
- instr_ready  in  1  consumer takes the head word this cycle.
- count  out  $clog2(DEPTH+1)  number of words in the FIFO.
- phase  out  2  nibble index of the next accepted nibble, 0..2.

## Operation
- Nibble transfer: in_valid && in_ready at a rising edge. Word transfer: instr_valid && instr_ready at a rising edge.
- Assembler: phase 0 loads bits [11:8], phase 1 loads [7:4], phase 2 loads [3:0].
  - Phase 0 → 1 → 2 → 0, advancing only on a nibble transfer.
  - The phase-2 transfer pushes {hold[11:4], in_data} into the FIFO. The word never waits in the assembler.
- in_ready = !flush && (phase != 2 || count != DEPTH). in_ready has no combinational path from instr_ready.
- instr_valid = (count != 0). instruction = head entry when count != 0, else 12'h000.
- Push and pop in the same cycle: count unchanged and order preserved. Push with no pop: count+1. Pop with no push: count−1.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Flush, when asserted at an edge:
  - count → 0, pointers → 0, phase → 0, partial word discarded.
  - Any nibble presented in that cycle is not accepted, because in_ready is low.
  - A word handshake in the flush cycle counts as consumed. Flush still wins and count → 0.
- instr_valid may drop only through a pop or a flush. instruction must hold stable while instr_valid && !instr_ready.
- in_valid low while phase 1 or 2 leaves the partial word held indefinitely. There is no timeout.

## Timing
- Reset values: in_ready 1, instr_valid 0, instruction 12'h000, count 0, phase 0. Holding registers and storage reset to 0.
- Reset mid-word or with the FIFO non-empty returns everything to the reset values immediately (asynchronous).
- Latency: a phase-2 transfer at edge N into an empty FIFO gives instr_valid = 1 and the word on instruction after edge N.
- Steady-state throughput is one word per 3 cycles, limited by the input port. The output side sustains one pop per cycle.
- Full FIFO with phase = 2: in_ready = 0. A pop at edge N raises in_ready after edge N, so the held nibble is accepted at edge N+1 at the earliest.
- Phases 0 and 1 accept nibbles even when the FIFO is full.

## Structure
- Shared package instr_pkg: INSTR_W = 12, NIBBLE_W = 4, NIBBLES_PER_INSTR = 3, instr_t = logic [11:0].
- The processor and scheduler import the same package.
- Sub-module instr_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/flush inputs and count output.
- instr_loader contains the assembler (phase counter plus 8-bit holding register) and instantiates instr_fifo.

## Test plan
- Reset, then nibbles 4'hA, 4'h5, 4'h3 on consecutive cycles with instr_ready = 0 → instr_valid rises the cycle after the third nibble; instruction = 12'hA53, count = 1.
- Stream five words 12'h101..12'h105 with instr_ready = 0 → count saturates at 4. in_ready goes low only at phase 2 of the fifth word. Draining yields 101, 102, 103, 104, then the fifth word is accepted.
- Continuous input with instr_ready = 1 → each word is popped one cycle after its third nibble, count stays ≤ 1, and order matches input.
- Two nibbles of 12'hF0? sent, then flush for 1 cycle, then 12'h123 → output is 12'h123 only. phase = 0 after the flush.
- FIFO holds 2 words; flush and instr_ready asserted in the same cycle → count = 0 and instr_valid = 0 next cycle. A nibble offered in the flush cycle is not accepted.
- Assert reset asynchronously mid-word with count = 3 → all outputs take their reset values before the next edge. The next three nibbles form a fresh word.
